wb_grf: RTL and testbench
=========================

# wb_grf

W-stage writeback unit and general register file for the five-stage MIPS core. It sits at the consumer end of the M/W pipeline register. It decodes the W-stage instruction to choose the writeback value from ALU result, load data, link address, HI or LO. It commits that value to the 32×32 GRF, serves the two D-stage read ports and exports the W-stage forwarding value to the hazard/forwarding logic. It also keeps a retired-instruction counter.

## Interface
Parameters:
- `NREG`, default 32: number of architectural registers. Fixed at 32; register 0 is hardwired to zero.
- `RET_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, synchronous, active-high.
- `W_ALUResult`, input, 32: ALU result from the M/W register.
- `W_DMRD`, input, 32: load data from the M/W register.
- `W_PC`, input, 32: PC of the W-stage instruction.
- `W_Instr`, input, 32: W-stage instruction word. Zero means bubble.
- `W_A3`, input, 5: destination register. Zero means no write.
- `W_HI`, input, 32: HI value carried with the instruction.
- `W_LO`, input, 32: LO value carried with the instruction.
- `D_A1`, input, 5: read address, port 1.
- `D_A2`, input, 5: read address, port 2.
- `D_RD1`, output, 32: read data, port 1.
- `D_RD2`, output, 32: read data, port 2.
- `W_WD`, output, 32: selected writeback value, used for forwarding.
- `W_WE`, output, 1: a GRF write happens this cycle.
- `ret_cnt`, output, RET_W: count of retired non-bubble instructions.

## Operation
- Decode uses `op = W_Instr[31:26]` and `funct = W_Instr[5:0]`. The first matching row wins:
  - Load: op is 0x20, 0x21, 0x23, 0x24 or 0x25 → `W_WD = W_DMRD`.
  - jal (op 0x03), or jalr (op 0x00, funct 0x09) → `W_WD = W_PC + 8`, mod 2^32.
  - mfhi (op 0x00, funct 0x10) → `W_WD = W_HI`.
  - mflo (op 0x00, funct 0x12) → `W_WD = W_LO`.
  - Anything else → `W_WD = W_ALUResult`.
- `W_WE = (W_A3 != 0) && !reset`. Decode does not affect `W_WE`; the destination is already resolved upstream.
- Write: on a rising edge with `W_WE` = 1, set `grf[W_A3] <= W_WD`.
- `grf[0]` always reads 0. Writes to register 0 cannot occur, because `W_WE` is 0 when `W_A3` = 0.
- Reads are combinational: `D_RDn = grf[D_An]`, subject to bypass (see Configuration).
- Retired-instruction counter:
  - `ret_cnt` increments by 1 on each rising edge where `W_Instr != 0` and reset is low.
  - It wraps from 2^RET_W−1 to 0.
  - Bubbles (`W_Instr` = 0) do not count.
- Reset, at a rising edge with `reset` = 1:
  - All registers 1..31 are set to 0 and `ret_cnt` is set to 0.
  - No write and no count occur in that cycle.
  - Reset asserted mid-stream discards the in-flight W instruction; it is neither written nor counted.
- Output values after reset:
  - `D_RD1` and `D_RD2` read 0 for every address.
  - `ret_cnt` = 0.
  - `W_WD` and `W_WE` are combinational functions of the inputs; `W_WE` is forced to 0 while `reset` is high.

## Timing
- Write latency: 1 cycle. The value is visible in the array from the cycle after the write edge.
- Read ports have zero-cycle combinational latency.
- `W_WD` and `W_WE` are valid in the same cycle as the W inputs. They carry no register stage.
- Same-cycle read and write of the same nonzero register is resolved by the bypass feature.
- Simultaneous `D_A1 == D_A2 == W_A3` gives both ports the same value.
- Read address 0 always returns 0, even when `W_A3` = 0.

## Configuration
- Macro `GRF_BYPASS_EN`.
- When defined: if `W_WE` = 1 and `D_An == W_A3`, then `D_RDn = W_WD` (write-first). The D stage needs no separate W→D forward path.
- When undefined: reads return the pre-edge array contents (read-first). The external forwarding unit must supply W→D forwarding.
- In both builds, bypass never applies while `reset` is high or when the address is 0.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants: `OP_SPECIAL`, `OP_JAL`, `OP_LB`, `OP_LH`, `OP_LW`, `OP_LBU`, `OP_LHU`;
  - funct constants: `FN_JALR`, `FN_MFHI`, `FN_MFLO`;
  - the writeback-select enum `wb_sel_t`, with values ALU, DM, PC8, HI, LO.
- Sub-module `wb_sel`: a purely combinational decoder plus mux producing `W_WD`. The register array, bypass and counter stay in `wb_grf`.

## Test plan
- Reset, then read all 32 addresses → all 0; `ret_cnt` = 0.
- Write path: `W_Instr` = addu, `W_A3` = 8, `W_ALUResult` = 0x1234 → next cycle `D_RD1` with `D_A1` = 8 reads 0x1234; `ret_cnt` = 1.
- Source select, one case per cycle:
  - lw, `W_A3` = 9, `W_DMRD` = 0xDEADBEEF → grf[9] = 0xDEADBEEF.
  - jal, `W_A3` = 31, `W_PC` = 0x3000 → grf[31] = 0x3008.
  - mfhi, `W_HI` = 0x55 → 0x55 written.
  - mflo, `W_LO` = 0xAA → 0xAA written.
- Bypass: write 0x77 to register 5 while `D_A2` = 5 in the same cycle → `D_RD2` = 0x77 with `GRF_BYPASS_EN` defined; the old value without it.
- Zero and bubbles:
  - `W_A3` = 0 with `W_ALUResult` = 0xFFFF → `W_WE` = 0 and grf[0] reads 0.
  - `W_Instr` = 0 for 3 cycles → `ret_cnt` unchanged.
- Reset mid-operation: assert reset in the same cycle as a write of 0x99 to register 4 → grf[4] = 0 and `ret_cnt` = 0. Separately, preload `ret_cnt` = 0xFFFFFFFF and retire one instruction → `ret_cnt` = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct constants and the writeback-select decode for the MIPS core
package mips_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MFLO    = 6'h12;

  typedef enum logic [2:0] {WB_ALU, WB_DM, WB_PC8, WB_HI, WB_LO} wb_sel_t;

  // First matching row wins: loads, then links, then HI/LO moves, else ALU.
  function automatic wb_sel_t wb_decode(input logic [31:0] instr);
    logic [5:0] op, fn;
    logic is_ld, is_sp;
    op = instr[31:26];
    fn = instr[5:0];
    is_sp = op == OP_SPECIAL;
    is_ld = op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
    return is_ld ? WB_DM :
           (op == OP_JAL || (is_sp && fn == FN_JALR)) ? WB_PC8 :
           (is_sp && fn == FN_MFHI) ? WB_HI :
           (is_sp && fn == FN_MFLO) ? WB_LO : WB_ALU;
  endfunction
endpackage

// File: rtl/wb_sel.sv
// wb_sel: combinational W-stage decoder and writeback-value mux
module wb_sel
  import mips_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] dmrd_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] wd_o
);
  wb_sel_t sel;
  // pick the writeback source from the decoded instruction class
  always_comb begin
    sel = wb_decode(instr_i);
    wd_o = sel == WB_DM  ? dmrd_i :
           sel == WB_PC8 ? pc_i + 32'd8 :
           sel == WB_HI  ? hi_i :
           sel == WB_LO  ? lo_i : alu_i;
  end
endmodule

// File: rtl/wb_grf.sv
// wb_grf: W-stage writeback, 32x32 GRF with two read ports, retired-instruction counter.
// Define GRF_BYPASS_EN for write-first reads; default is read-first.
module wb_grf
  import mips_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      W_ALUResult,
  input  logic [31:0]      W_DMRD,
  input  logic [31:0]      W_PC,
  input  logic [31:0]      W_Instr,
  input  logic [4:0]       W_A3,
  input  logic [31:0]      W_HI,
  input  logic [31:0]      W_LO,
  input  logic [4:0]       D_A1,
  input  logic [4:0]       D_A2,
  output logic [31:0]      D_RD1,
  output logic [31:0]      D_RD2,
  output logic [31:0]      W_WD,
  output logic             W_WE,
  output logic [RET_W-1:0] ret_cnt
);
  logic [31:0]      grf_q [NREG];
  logic [RET_W-1:0] ret_q, ret_d;

  wb_sel u_sel (
    .instr_i(W_Instr),
    .alu_i  (W_ALUResult),
    .dmrd_i (W_DMRD),
    .pc_i   (W_PC),
    .hi_i   (W_HI),
    .lo_i   (W_LO),
    .wd_o   (W_WD)
  );

  // write enable and counter next state; bubbles do not retire
  always_comb begin
    W_WE = W_A3 != 5'd0 && !reset;
    ret_d = ret_q + RET_W'(W_Instr != 32'd0);
  end

  // register 0 reads zero; W_WE already excludes reset and address 0
  always_comb begin
`ifdef GRF_BYPASS_EN
    D_RD1 = D_A1 == 5'd0 ? 32'd0 : (W_WE && D_A1 == W_A3) ? W_WD : grf_q[D_A1];
    D_RD2 = D_A2 == 5'd0 ? 32'd0 : (W_WE && D_A2 == W_A3) ? W_WD : grf_q[D_A2];
`else
    D_RD1 = D_A1 == 5'd0 ? 32'd0 : grf_q[D_A1];
    D_RD2 = D_A2 == 5'd0 ? 32'd0 : grf_q[D_A2];
`endif
    ret_cnt = ret_q;
  end

  // commit writeback and count retirements; reset discards the in-flight instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) grf_q[i] <= '0;
      ret_q <= '0;
    end else begin
      if (W_WE) grf_q[W_A3] <= W_WD;
      ret_q <= ret_d;
    end
  end
endmodule

// File: tb/tb_wb_grf.sv
// tb_wb_grf: directed bench for wb_grf with a reference model and literal spot checks
module tb_wb_grf;
  logic clk = 0, reset = 1;
  logic [31:0] alu = 0, dm = 0, pc = 0, instr = 0, hi = 0, lo = 0;
  logic [4:0] a3 = 0, a1 = 0, a2 = 0;
  logic [31:0] rd1, rd2, wd, rd1s, rd2s, wds;
  logic we, wes;
  logic [31:0] ret;
  logic [1:0] ret_s;
  int total = 0, bad = 0;
  bit started = 0;
  logic [31:0] m_reg [32];
  logic [31:0] m_ret = 0;

  localparam logic [31:0] ADDU = 32'h0109_5021, LW = 32'h8C09_0000, JAL = 32'h0C00_0C00;
  localparam logic [31:0] MFHI = 32'h0000_5010, MFLO = 32'h0000_5812, JALR = 32'h0200_F809;

  always #5 clk = ~clk;

  wb_grf dut (.clk(clk), .reset(reset), .W_ALUResult(alu), .W_DMRD(dm), .W_PC(pc),
    .W_Instr(instr), .W_A3(a3), .W_HI(hi), .W_LO(lo), .D_A1(a1), .D_A2(a2),
    .D_RD1(rd1), .D_RD2(rd2), .W_WD(wd), .W_WE(we), .ret_cnt(ret));

  wb_grf #(.RET_W(2)) dut_s (.clk(clk), .reset(reset), .W_ALUResult(alu), .W_DMRD(dm), .W_PC(pc),
    .W_Instr(instr), .W_A3(a3), .W_HI(hi), .W_LO(lo), .D_A1(a1), .D_A2(a2),
    .D_RD1(rd1s), .D_RD2(rd2s), .W_WD(wds), .W_WE(wes), .ret_cnt(ret_s));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_wd();
    int op, fn;
    op = int'(instr[31:26]);
    fn = int'(instr[5:0]);
    if (op inside {'h20, 'h21, 'h23, 'h24, 'h25}) return dm;
    if (op == 3 || (op == 0 && fn == 9)) return pc + 8;
    if (op == 0 && fn == 'h10) return hi;
    if (op == 0 && fn == 'h12) return lo;
    return alu;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 0) return 0;
`ifdef GRF_BYPASS_EN
    if (!reset && a == a3) return m_wd();
`endif
    return m_reg[a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_reg[i] = 0;
      m_ret = 0;
    end else begin
      if (a3 != 0) m_reg[a3] = m_wd();
      if (instr != 0) m_ret = m_ret + 1;
    end
  end

  always @(negedge clk) if (started) begin
    chk("wd", wd, m_wd());
    chk("we", {31'd0, we}, {31'd0, a3 != 0 && !reset});
    chk("rd1", rd1, m_rd(a1));
    chk("rd2", rd2, m_rd(a2));
    chk("ret", ret, m_ret);
    chk("ret_small", {30'd0, ret_s}, m_ret % 4);
    chk("wd_small", wds, wd);
  end

  task automatic drive(input logic r, input logic [31:0] ins, input logic [4:0] d, input logic [31:0] al,
                       input logic [31:0] dmv, input logic [31:0] pcv, input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk); #1;
    reset = r; instr = ins; a3 = d; alu = al; dm = dmv; pc = pcv; a1 = r1; a2 = r2;
    @(negedge clk);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    started = 1;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
      chk("reset_rd1", rd1, 0);
      chk("reset_rd2", rd2, 0);
    end
    chk("reset_ret", ret, 0);
    drive(0, ADDU, 8, 32'h1234, 32'h5, 32'h400, 0, 0);
    chk("addu_we", {31'd0, we}, 1);
    chk("addu_wd", wd, 32'h1234);
    drive(0, 0, 0, 0, 0, 0, 8, 0);
    chk("addu_rd", rd1, 32'h1234);
    chk("addu_ret", ret, 1);
    hi = 32'h55; lo = 32'hAA;
    drive(0, LW, 9, 32'h1111, 32'hDEADBEEF, 32'h2000, 0, 0);
    chk("lw_wd", wd, 32'hDEADBEEF);
    drive(0, JAL, 31, 32'h2222, 32'h3333, 32'h3000, 0, 0);
    chk("jal_wd", wd, 32'h3008);
    drive(0, MFHI, 10, 32'h4444, 32'h6666, 32'h3004, 0, 0);
    drive(0, MFLO, 11, 32'h7777, 32'h8888, 32'h3008, 0, 0);
    chk("ret_small_wrap", {30'd0, ret_s}, 0);
    drive(0, JALR, 12, 32'h9999, 32'hAAAA, 32'hFFFFFFFC, 0, 0);
    chk("jalr_wrap_wd", wd, 32'h4);
    drive(0, 0, 0, 0, 0, 0, 9, 31);
    chk("lw_rd", rd1, 32'hDEADBEEF);
    chk("jal_rd", rd2, 32'h3008);
    drive(0, 0, 0, 0, 0, 0, 10, 11);
    chk("mfhi_rd", rd1, 32'h55);
    chk("mflo_rd", rd2, 32'hAA);
    drive(0, ADDU, 5, 32'h77, 0, 0, 0, 5);
`ifdef GRF_BYPASS_EN
    chk("bypass_rd2", rd2, 32'h77);
`else
    chk("nobypass_rd2", rd2, 0);
`endif
    drive(0, ADDU, 5, 32'h88, 0, 0, 5, 5);
`ifdef GRF_BYPASS_EN
    chk("same_rd1", rd1, 32'h88);
`else
    chk("same_rd1", rd1, 32'h77);
`endif
    chk("same_ports", rd1, rd2);
    drive(0, ADDU, 0, 32'hFFFF, 0, 0, 0, 0);
    chk("zero_we", {31'd0, we}, 0);
    chk("zero_rd", rd1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 32'h1, 0, 0, 5, 12);
    chk("bubble_ret", ret, 9);
    chk("bubble_rd1", rd1, 32'h88);
    chk("jalr_rd", rd2, 32'h4);
    drive(1, ADDU, 4, 32'h99, 0, 0, 4, 4);
    chk("rst_we", {31'd0, we}, 0);
    drive(0, 0, 0, 0, 0, 0, 4, 8);
    chk("rst_rd4", rd1, 0);
    chk("rst_rd8", rd2, 0);
    chk("rst_ret", ret, 0);
    drive(0, ADDU, 3, 32'hCAFE, 0, 0, 3, 0);
    drive(0, 0, 0, 0, 0, 0, 3, 0);
    chk("post_rst_rd", rd1, 32'hCAFE);
    chk("post_rst_ret", ret, 1);
    started = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
